vram_stroke_writer: RTL
=======================

Name: vram_stroke_writer

Overview:
- Sits between the touch controller output (touch0) and the VRAM write port of the etch-a-sketch.
- Turns a stream of sampled touch points into VRAM pixel writes. Consecutive pen-down samples are joined with Bresenham line segments, so fast strokes have no gaps.
- Also owns whole-screen clearing: after reset, and on request.
- Sole driver of the VRAM write port; the display controller remains the only reader.

Parameters:
- DISPLAY_WIDTH, 240, pixels per row; x range 0..DISPLAY_WIDTH-1.
- DISPLAY_HEIGHT, 320, rows; y range 0..DISPLAY_HEIGHT-1.
- VRAM_L, DISPLAY_WIDTH*DISPLAY_HEIGHT, number of VRAM words.
- VRAM_W, 16, pixel width (RGB565).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- touch_valid  input  1  touch present (level, from the touch controller).
- touch_x  input  9  touch x coordinate.
- touch_y  input  9  touch y coordinate.
- draw_color  input  VRAM_W  stroke colour, sampled when a point is accepted.
- clear_color  input  VRAM_W  fill colour, sampled when a clear starts.
- clear_req  input  1  single-cycle pulse requesting a full clear.
- vram_wr_ena  output  1  VRAM write strobe.
- vram_wr_addr  output  $clog2(VRAM_L)  write address, equal to y*DISPLAY_WIDTH+x.
- vram_wr_data  output  VRAM_W  write data.
- busy  output  1  high while clearing or drawing a segment.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=0.
  - busy=1, pen_down=0, last point=(0,0).
  - state=S_CLEAR, clear counter=0.
- S_CLEAR:
  - Each cycle writes clear_color (latched on entry) to counter address, ascending from 0 to VRAM_L-1, one write per cycle.
  - First write is the cycle after rst deasserts; exactly VRAM_L writes.
  - Then goes to S_IDLE with busy=0.
  - Touch inputs are ignored; pen_down is held 0.
- S_IDLE:
  - touch_valid=0 clears pen_down.
  - touch_valid=1 with touch_x>=DISPLAY_WIDTH or touch_y>=DISPLAY_HEIGHT: point rejected, pen_down cleared, no write.
  - Valid in-range point P with pen_down=1 and P equal to the last point: no action (de-duplication).
  - Otherwise accept at cycle N:
    - Start point = last point if pen_down, else P.
    - End point = P; latch draw_color; go to S_SETUP.
    - Set pen_down=1 and last point=P.
- S_SETUP (N+1):
  - Register dx=|x1-x0|, dy=-|y1-y0| (10-bit signed), sx/sy=±1, err=dx+dy (11-bit signed).
  - busy=1 from N+1.
- S_LINE (from N+2):
  - One pixel write per cycle, start to end inclusive: max(|dx|,|dy|)+1 writes, first at N+2.
  - Step rule with e2=2*err (12-bit signed):
    - if e2>=dy: err+=dy, x+=sx;
    - if e2<=dx: err+=dx, y+=sy.
    - Both may apply in one cycle.
  - Address uses the registered x,y: y*DISPLAY_WIDTH+x, no wrap (all points are in range).
  - After the write at the end point, go to S_IDLE; busy=0 and vram_wr_ena=0 the following cycle.
- Touch samples arriving during S_SETUP/S_LINE are dropped. A touch_valid=0 seen in any non-clear state clears pen_down, so a lift mid-segment starts a new stroke.
- clear_req in any state (including S_CLEAR) has priority:
  - The next cycle enters S_CLEAR with counter=0; any in-flight segment is abandoned with no further writes.
  - pen_down is cleared.
- clear_req simultaneous with rst: rst wins; the result is identical either way.
- vram_wr_ena is 0 in S_IDLE and S_SETUP.

Test Plan:
- Release rst: exactly 76800 writes, addr 0..76799 ascending, data=clear_color, with no gaps. busy falls one cycle after addr 76799 is written.
- After clear, touch (10,20) with pen up: one write at N+2, addr 4810, data=draw_color; busy high for N+1..N+2.
- Hold pen, then (13,21): writes addr 4810, 4811, 5052, 5053, i.e. points (10,20),(11,20),(12,21),(13,21), on consecutive cycles.
- Pen up, then (0,319) then (0,316):
  - Single write at addr 76560.
  - Then writes 76560, 76320, 76080, 75840.
  - Repeating (0,316) while held produces no writes.
- Touch (240,5), then (3,3): no write for the first point. The second point is drawn as a single point (pen_down was cleared), addr 723.
- Start a segment (0,0)->(200,0); pulse clear_req after 5 writes: no segment writes afterwards, next cycle clear begins at addr 0, and a touch during the clear produces no writes.

Source files
------------

// File: rtl/vram_stroke_writer_if.sv
// Touch/clear request inputs and the VRAM write port of the stroke writer.
// The writer takes the slave view; whatever feeds touches and watches VRAM writes takes the master view.
interface vram_stroke_writer_if #(
    parameter int VRAM_W = 16,
    parameter int ADDR_W = 17
);
    logic              touch_valid;
    logic [8:0]        touch_x;
    logic [8:0]        touch_y;
    logic [VRAM_W-1:0] draw_color;
    logic [VRAM_W-1:0] clear_color;
    logic              clear_req;
    logic              vram_wr_ena;
    logic [ADDR_W-1:0] vram_wr_addr;
    logic [VRAM_W-1:0] vram_wr_data;
    logic              busy;

    modport master (
        output touch_valid, touch_x, touch_y, draw_color, clear_color, clear_req,
        input  vram_wr_ena, vram_wr_addr, vram_wr_data, busy
    );
    modport slave (
        input  touch_valid, touch_x, touch_y, draw_color, clear_color, clear_req,
        output vram_wr_ena, vram_wr_addr, vram_wr_data, busy
    );
endinterface

// File: rtl/vram_stroke_writer.sv
// Turns touch samples into VRAM pixel writes, joining pen-down points with Bresenham
// segments, and fills the whole screen after reset or on a clear request.
module vram_stroke_writer #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int VRAM_W         = 16
) (
    input logic                 clk,
    input logic                 rst,
    vram_stroke_writer_if.slave bus
);
    localparam int AW = $clog2(VRAM_L);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SETUP, S_LINE} state_e;
    state_e state_q, state_d;

    logic [AW-1:0]      cnt_q, cnt_d;
    logic [VRAM_W-1:0]  clr_col_q, clr_col_d, col_q, col_d;
    logic               pen_q, pen_d;
    logic [8:0]         lx_q, lx_d, ly_q, ly_d;
    logic [8:0]         x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
    logic signed [9:0]  dx_q, dx_d, dy_q, dy_d;
    logic               sxn_q, sxn_d, syn_q, syn_d;
    logic signed [10:0] err_q, err_d;
    logic               wr_ena_q, wr_ena_d, busy_q, busy_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [VRAM_W-1:0]  wr_data_q, wr_data_d;

    logic               in_range, same_pt, accept, at_end, step_x, step_y;
    logic signed [9:0]  xd, yd;
    logic signed [11:0] e2, dx12, dy12;
    logic signed [10:0] dx11, dy11;

    function automatic logic [AW-1:0] pix_addr(input logic [8:0] px, input logic [8:0] py);
        return AW'(py) * AW'(DISPLAY_WIDTH) + AW'(px);
    endfunction

    assign in_range = (bus.touch_x < 9'(DISPLAY_WIDTH)) && (bus.touch_y < 9'(DISPLAY_HEIGHT));
    assign same_pt  = pen_q && (bus.touch_x == lx_q) && (bus.touch_y == ly_q);
    assign accept   = (state_q == S_IDLE) && bus.touch_valid && in_range && !same_pt;
    assign at_end   = (x_q == x1_q) && (y_q == y1_q);

    assign xd   = $signed({1'b0, x1_q}) - $signed({1'b0, x_q});
    assign yd   = $signed({1'b0, y1_q}) - $signed({1'b0, y_q});
    assign dx11 = {dx_q[9], dx_q};
    assign dy11 = {dy_q[9], dy_q};
    assign dx12 = {{2{dx_q[9]}}, dx_q};
    assign dy12 = {{2{dy_q[9]}}, dy_q};
    assign e2   = {err_q, 1'b0};
    assign step_x = (e2 >= dy12);
    assign step_y = (e2 <= dx12);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_CLEAR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear_req) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_CLEAR: if (cnt_q == AW'(VRAM_L - 1)) state_d = S_IDLE;
                S_IDLE:  if (accept) state_d = S_SETUP;
                S_SETUP: state_d = S_LINE;
                S_LINE:  if (at_end) state_d = S_IDLE;
                default: state_d = S_CLEAR;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;  clr_col_d = clr_col_q;  col_d = col_q;
        lx_d = lx_q;    ly_d = ly_q;
        x_d = x_q;      y_d = y_q;  x1_d = x1_q;  y1_d = y1_q;
        dx_d = dx_q;    dy_d = dy_q;  sxn_d = sxn_q;  syn_d = syn_q;  err_d = err_q;
        wr_ena_d = 1'b0;  wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;

        // A lift or an off-screen sample always breaks the stroke; clearing holds the pen up.
        pen_d = pen_q;
        if (bus.clear_req || state_q == S_CLEAR || !bus.touch_valid) pen_d = 1'b0;
        else if (state_q == S_IDLE && !in_range)                     pen_d = 1'b0;
        else if (accept)                                             pen_d = 1'b1;

        if (bus.clear_req) begin
            cnt_d     = '0;
            clr_col_d = bus.clear_color;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    wr_ena_d  = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = clr_col_q;
                    cnt_d     = cnt_q + 1'b1;
                end
                S_IDLE: if (accept) begin
                    x_d   = pen_q ? lx_q : bus.touch_x;
                    y_d   = pen_q ? ly_q : bus.touch_y;
                    x1_d  = bus.touch_x;
                    y1_d  = bus.touch_y;
                    lx_d  = bus.touch_x;
                    ly_d  = bus.touch_y;
                    col_d = bus.draw_color;
                end
                S_SETUP: begin
                    dx_d      = (xd < 0) ? -xd : xd;
                    dy_d      = (yd < 0) ? yd : -yd;
                    sxn_d     = (xd < 0);
                    syn_d     = (yd < 0);
                    err_d     = {dx_d[9], dx_d} + {dy_d[9], dy_d};
                    wr_ena_d  = 1'b1;
                    wr_addr_d = pix_addr(x_q, y_q);
                    wr_data_d = col_q;
                end
                S_LINE: if (!at_end) begin
                    // The output register always holds the pixel at (x_q, y_q); step to the next one.
                    err_d = err_q + (step_x ? dy11 : 11'sd0) + (step_y ? dx11 : 11'sd0);
                    if (step_x) x_d = sxn_q ? x_q - 9'd1 : x_q + 9'd1;
                    if (step_y) y_d = syn_q ? y_q - 9'd1 : y_q + 9'd1;
                    wr_ena_d  = 1'b1;
                    wr_addr_d = pix_addr(x_d, y_d);
                    wr_data_d = col_q;
                end
                default: ;
            endcase
        end
        busy_d = (state_d != S_IDLE) || wr_ena_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;  clr_col_q <= bus.clear_color;  col_q <= '0;
            pen_q <= 1'b0;  lx_q <= '0;  ly_q <= '0;
            x_q <= '0;  y_q <= '0;  x1_q <= '0;  y1_q <= '0;
            dx_q <= '0;  dy_q <= '0;  sxn_q <= 1'b0;  syn_q <= 1'b0;  err_q <= '0;
            wr_ena_q <= 1'b0;  wr_addr_q <= '0;  wr_data_q <= '0;  busy_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;  clr_col_q <= clr_col_d;  col_q <= col_d;
            pen_q <= pen_d;  lx_q <= lx_d;  ly_q <= ly_d;
            x_q <= x_d;  y_q <= y_d;  x1_q <= x1_d;  y1_q <= y1_d;
            dx_q <= dx_d;  dy_q <= dy_d;  sxn_q <= sxn_d;  syn_q <= syn_d;  err_q <= err_d;
            wr_ena_q <= wr_ena_d;  wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;  busy_q <= busy_d;
        end
    end

    assign bus.vram_wr_ena  = wr_ena_q;
    assign bus.vram_wr_addr = wr_addr_q;
    assign bus.vram_wr_data = wr_data_q;
    assign bus.busy         = busy_q;
endmodule
